// File: rtl/veririsc_pkg.sv
// veririsc_pkg: opcode and sequencer-state encodings shared by the VeriRISC blocks
package veririsc_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;
  function automatic logic is_aluop(input opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction
endpackage

// File: rtl/veririsc_controller.sv
// veririsc_controller: eight-phase fetch/execute sequencer driving the VeriRISC datapath enables
module veririsc_controller
  import veririsc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  opcode_t    opcode,
  input  logic       zero,
  output logic       mem_rd,
  output logic       load_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       load_ac,
  output logic       load_pc,
  output logic       mem_wr,
  output logic [3:0] phase
);
  state_t state, next_state;
  logic alu, exec;
  // phase register; active-low reset abandons any instruction, halted or not
  always_ff @(posedge clk)
    if (!reset) state <= INST_ADDR;
    else state <= next_state;
  // next phase and combinational enable decode from (phase, opcode, zero)
  always_comb begin
    alu = is_aluop(opcode);
    exec = state inside {ALU_OP, STORE};
    next_state = state == HALTED ? HALTED :
                 (state == OP_ADDR && opcode == HLT) ? HALTED :
                 state == STORE ? INST_ADDR : state_t'(state + 4'd1);
    mem_rd = state inside {INST_FETCH, INST_LOAD, IDLE} || (state inside {OP_FETCH, ALU_OP, STORE} && alu);
    load_ir = state inside {INST_LOAD, IDLE};
    halt = state == HALTED || (state == OP_ADDR && opcode == HLT);
    inc_pc = state == OP_ADDR || (state == ALU_OP && opcode == SKZ && zero) || (state == STORE && opcode == JMP);
    load_ac = exec && alu;
    load_pc = exec && opcode == JMP;
    mem_wr = state == STORE && opcode == STO;
    phase = state;
  end
endmodule

// File: tb/tb_veririsc_controller.sv
// tb_veririsc_controller: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_veririsc_controller;
  import veririsc_pkg::*;
  logic clk = 1'b0;
  logic reset, zero;
  opcode_t opcode;
  logic mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  logic [3:0] phase;
  logic [10:0] exp_q[$];
  string tag_q[$];
  int checks = 0;
  int fails = 0;

  veririsc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
    .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .phase(phase)
  );

  always #5 clk = ~clk;

  // expected word is {phase, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
  task automatic step(input string tag, input logic [3:0] ph, input logic [6:0] en);
    exp_q.push_back({ph, en});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // one full instruction; masks give the hand-derived enable per phase (bit i = phase i)
  task automatic instr(input string tag, input opcode_t op, input logic z, input logic abort,
                       input logic [7:0] rd, input logic [7:0] ir, input logic [7:0] pc,
                       input logic [7:0] ac, input logic [7:0] ld, input logic [7:0] wr);
    for (int p = 0; p < 8; p++) begin
      reset = !(abort && p == 7);
      opcode = op;
      zero = z;
      step(tag, 4'(p), {rd[p], ir[p], 1'b0, pc[p], ac[p], ld[p], wr[p]});
    end
  endtask

  // monitor: every falling edge with a pending expectation is one comparison
  always @(negedge clk) begin
    logic [10:0] e, got;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      got = {phase, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s: phase+enables got %b expected %b", t, got, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    opcode = ADD;
    zero = 1'b0;
    @(posedge clk);
    #1;
    step("reset_hold1", 4'd0, 7'b0);
    step("reset_hold2", 4'd0, 7'b0);
    instr("add",     ADD, 1'b0, 1'b0, 8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'h00, 8'h00);
    instr("add_z1",  ADD, 1'b1, 1'b0, 8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'h00, 8'h00);
    instr("and",     AND, 1'b0, 1'b0, 8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'h00, 8'h00);
    instr("xor",     XOR, 1'b1, 1'b0, 8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'h00, 8'h00);
    instr("lda",     LDA, 1'b0, 1'b0, 8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'h00, 8'h00);
    instr("skz_z1",  SKZ, 1'b1, 1'b0, 8'b00001110, 8'b00001100, 8'b01010000, 8'h00, 8'h00, 8'h00);
    instr("skz_z0",  SKZ, 1'b0, 1'b0, 8'b00001110, 8'b00001100, 8'b00010000, 8'h00, 8'h00, 8'h00);
    instr("jmp",     JMP, 1'b1, 1'b0, 8'b00001110, 8'b00001100, 8'b10010000, 8'h00, 8'b11000000, 8'h00);
    instr("sto",     STO, 1'b1, 1'b0, 8'b00001110, 8'b00001100, 8'b00010000, 8'h00, 8'h00, 8'b10000000);
    reset = 1'b1;
    opcode = HLT;
    zero = 1'b0;
    step("hlt_p0", 4'd0, 7'b0000000);
    step("hlt_p1", 4'd1, 7'b1000000);
    step("hlt_p2", 4'd2, 7'b1100000);
    step("hlt_p3", 4'd3, 7'b1100000);
    step("hlt_p4", 4'd4, 7'b0011000);
    for (int i = 0; i < 20; i++) begin
      opcode = opcode_t'(3'($urandom_range(0, 7)));
      zero = 1'($urandom_range(0, 1));
      reset = (i != 19);
      step("halted", 4'd8, 7'b0010000);
    end
    instr("add_after_halt", ADD, 1'b0, 1'b0, 8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'h00, 8'h00);
    instr("sto_abort", STO, 1'b0, 1'b1, 8'b00001110, 8'b00001100, 8'b00010000, 8'h00, 8'h00, 8'b10000000);
    instr("add_after_abort", ADD, 1'b1, 1'b0, 8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'h00, 8'h00);
    instr("jmp_final", JMP, 1'b0, 1'b0, 8'b00001110, 8'b00001100, 8'b10010000, 8'h00, 8'b11000000, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
